// File: rtl/symbol_packer_pkg.sv
// Shared widths, default constants and output-state encoding for the symbol packer.
package comm_pkg;

  localparam int SYMB_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [SYMB_W-1:0] DEF_SYNC_WORD = 16'hF0A5;
  localparam logic [BYTE_W-1:0] DEF_PAD_BYTE  = 8'h00;

  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } out_state_e;

endpackage

// File: rtl/symbol_packer_if.sv
// Byte-in / symbol-out handshake bundle; master is the packer, slave is its environment.
interface symbol_packer_if #(
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [comm_pkg::BYTE_W-1:0] byte_in;
  logic                        byte_valid;
  logic                        byte_ready;
  logic [comm_pkg::SYMB_W-1:0] symb_out;
  logic                        symb_valid;
  logic                        read_ready;
  logic                        frame_start;
  logic [CNT_W-1:0]            fifo_count;

  modport master (
    input  byte_in, byte_valid, read_ready,
    output byte_ready, symb_out, symb_valid, frame_start, fifo_count
  );

  modport slave (
    output byte_in, byte_valid, read_ready,
    input  byte_ready, symb_out, symb_valid, frame_start, fifo_count
  );

endinterface

// File: rtl/symbol_packer_fifo.sv
// DEPTH x WIDTH synchronous FIFO with combinational head read; occupancy tracked by a counter.
module symbol_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the counter so equal pointers are never ambiguous.
  assign push_ok = push && (count_q != FULL_CNT);
  assign pop_ok  = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/symbol_packer.sv
// Packs byte pairs into 16-bit symbols, buffers them and inserts a sync symbol every FRAME_LEN symbols.
// Define PACKER_FLUSH_EN to pad and push a lone held byte after FLUSH_CYCLES idle cycles.
module symbol_packer
  import comm_pkg::*;
#(
  parameter int                 DEPTH        = 4,
  parameter int                 FRAME_LEN    = 8,
  parameter logic [SYMB_W-1:0]  SYNC_WORD    = DEF_SYNC_WORD,
  parameter int                 FLUSH_CYCLES = 32,
  parameter logic [BYTE_W-1:0]  PAD_BYTE     = DEF_PAD_BYTE
) (
  input  logic             clk,
  input  logic             reset,
  symbol_packer_if.master  bus
);

  localparam int                CNT_W    = $clog2(DEPTH) + 1;
  localparam int                FRAME_W  = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("symbol_packer: DEPTH must be a power of 2 and at least 2");
  end
  if (FRAME_LEN < 1 || FLUSH_CYCLES < 1) begin : g_bad_len
    $error("symbol_packer: FRAME_LEN and FLUSH_CYCLES must be at least 1");
  end

  out_state_e          state_q;
  logic [FRAME_W-1:0]  frame_cnt_q;
  logic                half_valid_q, half_valid_d;
  logic [BYTE_W-1:0]   held_q, held_d;

  logic [SYMB_W-1:0]   fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic [SYMB_W-1:0]   push_data;
  logic                push;
  logic                sync_pending;
  logic                accept;
  logic                xfer;
  logic                data_pop;
  logic                flush_fire;

  assign sync_pending = (state_q == SYNC);

  // Outputs are forced inactive while reset is held, even though sync is already pending.
  assign bus.byte_ready  = reset && !(half_valid_q && fifo_count == FULL_CNT);
  assign bus.symb_valid  = reset && (sync_pending || fifo_count != '0);
  assign bus.frame_start = reset && sync_pending;
  assign bus.symb_out    = sync_pending ? SYNC_WORD : fifo_head;
  assign bus.fifo_count  = fifo_count;

  assign accept   = bus.byte_valid && bus.byte_ready;
  assign xfer     = bus.symb_valid && bus.read_ready;
  assign data_pop = xfer && !sync_pending;

`ifdef PACKER_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q;

  // idle_q holds the number of idle edges already seen; this edge is the FLUSH_CYCLES-th.
  assign flush_fire = half_valid_q && !accept && (idle_q == IDLE_LAST) && (fifo_count != FULL_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else if (accept || flush_fire || !half_valid_q) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_LAST) begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  assign flush_fire = 1'b0;
`endif

  assign push      = (accept && half_valid_q) || flush_fire;
  assign push_data = flush_fire ? {held_q, PAD_BYTE} : {held_q, bus.byte_in};

  always_comb begin
    half_valid_d = half_valid_q;
    held_d       = held_q;
    if (accept) begin
      half_valid_d = !half_valid_q;
      if (!half_valid_q) held_d = bus.byte_in;
    end else if (flush_fire) begin
      half_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_valid_q <= 1'b0;
      held_q       <= '0;
    end else begin
      half_valid_q <= half_valid_d;
      held_q       <= held_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SYNC;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        SYNC: if (xfer) state_q <= DATA;
        DATA: if (data_pop) begin
          if (frame_cnt_q == FRAME_W'(FRAME_LEN - 1)) begin
            frame_cnt_q <= '0;
            state_q     <= SYNC;
          end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  symbol_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SYMB_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (data_pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

endmodule
